// File: rtl/ppu_mmu_bridge_pkg.sv
// Shared definitions for the MMU-side PPU bridge: PPU modes, DMA states,
// address map constants and small decode helpers.
package ppu_mmu_bridge_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] VRAM_BASE      = 16'h8000;
  localparam logic [15:0] VRAM_END       = 16'h9FFF;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam logic [15:0] OAM_END        = 16'hFE9F;
  localparam logic [15:0] OAM_UNUSED_END = 16'hFEFF;
  localparam logic [15:0] PPU_REG_BASE   = 16'hFF40;
  localparam logic [15:0] PPU_REG_END    = 16'hFF4B;
  localparam logic [15:0] DMA_REG        = 16'hFF46;

  localparam logic [7:0] OPEN_BUS    = 8'hFF;
  localparam logic [7:0] ECHO_HI_MIN = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET = 8'h20;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // E0-FF pages are echo RAM; fold them back onto C0-DF.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] page);
    logic [7:0] result;
    if (page >= ECHO_HI_MIN) begin
      result = page - ECHO_OFFSET;
    end else begin
      result = page;
    end
    return result;
  endfunction

endpackage

// File: rtl/ppu_mmu_bridge_if.sv
// Bus bundle between the MMU bridge (master) and the CPU/PPU/memory side (slave).
interface ppu_mmu_bridge_if;
  import ppu_mmu_bridge_pkg::*;

  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  ppu_mode_t   ppu_mode;
  logic [15:0] reg_addr;
  logic        reg_write_en;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata;
  logic [15:0] dma_src_addr;
  logic        dma_src_rd;
  logic [7:0]  dma_src_rdata;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ppu_mode,
    input  reg_rdata, vram_rdata, oam_rdata, dma_src_rdata,
    output cpu_rdata, reg_addr, reg_write_en, reg_wdata,
    output vram_addr, vram_we, vram_wdata,
    output oam_addr, oam_we, oam_wdata,
    output dma_src_addr, dma_src_rd, dma_active
  );

  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ppu_mode,
    output reg_rdata, vram_rdata, oam_rdata, dma_src_rdata,
    input  cpu_rdata, reg_addr, reg_write_en, reg_wdata,
    input  vram_addr, vram_we, vram_wdata,
    input  oam_addr, oam_we, oam_wdata,
    input  dma_src_addr, dma_src_rd, dma_active
  );

endinterface

// File: rtl/ppu_mmu_bridge_oam_dma.sv
// OAM DMA engine: one START slot, then one source read and one OAM write
// per byte slot of DMA_CYCLES_PER_BYTE clocks.
module ppu_mmu_bridge_oam_dma
  import ppu_mmu_bridge_pkg::*;
#(
  parameter int DMA_CYCLES_PER_BYTE = 4,
  parameter int OAM_BYTES           = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  start_data_i,
  input  logic [7:0]  src_rdata_i,
  output logic        dma_active_o,
  output logic [15:0] src_addr_o,
  output logic        src_rd_o,
  output logic        oam_we_o,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_wdata_o,
  output logic [7:0]  shadow_o
);

  localparam logic [3:0] SLOT_LAST = 4'(DMA_CYCLES_PER_BYTE - 1);
  localparam logic [7:0] IDX_LAST  = 8'(OAM_BYTES - 1);

  dma_state_t state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] shadow_q, shadow_d;

  // State, slot counter, byte index and source/shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DMA_IDLE;
      slot_q   <= 4'd0;
      idx_q    <= 8'd0;
      src_hi_q <= 8'h00;
      shadow_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      src_hi_q <= src_hi_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic; a register write always restarts from START.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    src_hi_d = src_hi_q;
    shadow_d = shadow_q;
    if (start_i) begin
      shadow_d = start_data_i;
      src_hi_d = dma_src_hi(start_data_i);
      state_d  = DMA_START;
      slot_d   = 4'd0;
      idx_d    = 8'd0;
    end else begin
      case (state_q)
        DMA_IDLE: begin
          slot_d = 4'd0;
          idx_d  = 8'd0;
        end
        DMA_START: begin
          if (slot_q == SLOT_LAST) begin
            state_d = DMA_XFER;
            slot_d  = 4'd0;
            idx_d   = 8'd0;
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        DMA_XFER: begin
          if (slot_q == SLOT_LAST) begin
            slot_d = 4'd0;
            if (idx_q == IDX_LAST) begin
              state_d = DMA_IDLE;
              idx_d   = 8'd0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        default: begin
          state_d = DMA_IDLE;
          slot_d  = 4'd0;
          idx_d   = 8'd0;
        end
      endcase
    end
  end

  // Slot clock 0 issues the source read, slot clock 1 writes the returned byte.
  always_comb begin
    dma_active_o = (state_q != DMA_IDLE);
    src_addr_o   = {src_hi_q, idx_q};
    src_rd_o     = (state_q == DMA_XFER) && (slot_q == 4'd0);
    oam_we_o     = (state_q == DMA_XFER) && (slot_q == 4'd1);
    oam_addr_o   = idx_q;
    oam_wdata_o  = src_rdata_i;
    shadow_o     = shadow_q;
  end

endmodule

// File: rtl/ppu_mmu_bridge.sv
// MMU-side PPU bridge: CPU address decode toward PPU registers, VRAM/OAM
// access gating by PPU mode, and the FF46 OAM DMA engine.
module ppu_mmu_bridge
  import ppu_mmu_bridge_pkg::*;
#(
  parameter int DMA_CYCLES_PER_BYTE = 4,
  parameter int OAM_BYTES           = 160
) (
  input  logic              clk,
  input  logic              reset,
  ppu_mmu_bridge_if.master  bus
);

  generate
    if (DMA_CYCLES_PER_BYTE < 2 || DMA_CYCLES_PER_BYTE > 15) begin : g_bad_cpb
      $error("DMA_CYCLES_PER_BYTE must be within 2..15");
    end
    if (OAM_BYTES < 1 || OAM_BYTES > 256) begin : g_bad_oam_bytes
      $error("OAM_BYTES must be within 1..256");
    end
  endgenerate

  logic        dma_start_s;
  logic        dma_active_s;
  logic [15:0] dma_src_addr_s;
  logic        dma_src_rd_s;
  logic        dma_oam_we_s;
  logic [7:0]  dma_oam_addr_s;
  logic [7:0]  dma_oam_wdata_s;
  logic [7:0]  shadow_s;
  logic        in_reg_s;
  logic        in_vram_s;
  logic        in_oam_s;
  logic        in_oam_unused_s;
  logic        vram_lock_s;
  logic        oam_lock_s;

  assign dma_start_s = bus.cpu_wr && (bus.cpu_addr == DMA_REG);

  ppu_mmu_bridge_oam_dma #(
    .DMA_CYCLES_PER_BYTE (DMA_CYCLES_PER_BYTE),
    .OAM_BYTES           (OAM_BYTES)
  ) u_oam_dma (
    .clk          (clk),
    .rst_n        (reset),
    .start_i      (dma_start_s),
    .start_data_i (bus.cpu_wdata),
    .src_rdata_i  (bus.dma_src_rdata),
    .dma_active_o (dma_active_s),
    .src_addr_o   (dma_src_addr_s),
    .src_rd_o     (dma_src_rd_s),
    .oam_we_o     (dma_oam_we_s),
    .oam_addr_o   (dma_oam_addr_s),
    .oam_wdata_o  (dma_oam_wdata_s),
    .shadow_o     (shadow_s)
  );

  // Region decode and per-clock lock evaluation from the live PPU mode.
  always_comb begin
    in_reg_s        = in_range(bus.cpu_addr, PPU_REG_BASE, PPU_REG_END) &&
                      (bus.cpu_addr != DMA_REG);
    in_vram_s       = in_range(bus.cpu_addr, VRAM_BASE, VRAM_END);
    in_oam_s        = in_range(bus.cpu_addr, OAM_BASE, OAM_END);
    in_oam_unused_s = (bus.cpu_addr > OAM_END) && (bus.cpu_addr <= OAM_UNUSED_END);
    vram_lock_s     = (bus.ppu_mode == MODE_3);
    oam_lock_s      = (bus.ppu_mode == MODE_2) || (bus.ppu_mode == MODE_3) || dma_active_s;
  end

  // Write-side routing; the DMA engine owns the OAM port while active.
  always_comb begin
    bus.reg_addr     = bus.cpu_addr;
    bus.reg_wdata    = bus.cpu_wdata;
    bus.reg_write_en = bus.cpu_wr && in_reg_s;
    bus.vram_addr    = bus.cpu_addr[12:0];
    bus.vram_wdata   = bus.cpu_wdata;
    bus.vram_we      = bus.cpu_wr && in_vram_s && !vram_lock_s;
    bus.dma_src_addr = dma_src_addr_s;
    bus.dma_src_rd   = dma_src_rd_s;
    bus.dma_active   = dma_active_s;
    if (dma_active_s) begin
      bus.oam_addr  = dma_oam_addr_s;
      bus.oam_wdata = dma_oam_wdata_s;
      bus.oam_we    = dma_oam_we_s;
    end else begin
      bus.oam_addr  = bus.cpu_addr[7:0];
      bus.oam_wdata = bus.cpu_wdata;
      bus.oam_we    = bus.cpu_wr && in_oam_s && !oam_lock_s;
    end
  end

  // CPU read mux; undecoded space and idle cycles float to open bus.
  always_comb begin
    bus.cpu_rdata = OPEN_BUS;
    if (!bus.cpu_rd) begin
      bus.cpu_rdata = OPEN_BUS;
    end else if (in_reg_s) begin
      bus.cpu_rdata = bus.reg_rdata;
    end else if (bus.cpu_addr == DMA_REG) begin
      bus.cpu_rdata = shadow_s;
    end else if (in_vram_s) begin
      bus.cpu_rdata = vram_lock_s ? OPEN_BUS : bus.vram_rdata;
    end else if (in_oam_s) begin
      bus.cpu_rdata = oam_lock_s ? OPEN_BUS : bus.oam_rdata;
    end else if (in_oam_unused_s) begin
      bus.cpu_rdata = 8'h00;
    end else begin
      bus.cpu_rdata = OPEN_BUS;
    end
  end

endmodule

// File: tb/tb_ppu_mmu_bridge.sv
// Directed self-checking bench for ppu_mmu_bridge: decode, locks and OAM DMA.
module tb_ppu_mmu_bridge;
  import ppu_mmu_bridge_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_mmu_bridge_if bus();

  ppu_mmu_bridge #(
    .DMA_CYCLES_PER_BYTE (4),
    .OAM_BYTES           (160)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int active_cnt = 0;
  int we_cnt     = 0;
  int exp_idx    = 0;
  int stray_cnt  = 0;
  bit found;

  // Source memory returns the low address byte one clock after the read.
  always @(posedge clk) begin
    if (bus.dma_src_rd) begin
      bus.dma_src_rdata <= bus.dma_src_addr[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and monitor DMA traffic there.
  task automatic tick();
    @(negedge clk);
    if (bus.dma_active) begin
      active_cnt++;
      if (bus.oam_we) begin
        check("dma_oam_addr", {24'd0, bus.oam_addr}, exp_idx & 32'hFF);
        check("dma_oam_wdata", {24'd0, bus.oam_wdata}, exp_idx & 32'hFF);
        exp_idx++;
        we_cnt++;
      end
    end else if (bus.oam_we && !bus.cpu_wr) begin
      stray_cnt++;
    end
  endtask

  task automatic drive(input logic [15:0] addr, input logic rd, input logic wr,
                       input logic [7:0] wdata);
    bus.cpu_addr  = addr;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_wdata = wdata;
    #1;
  endtask

  task automatic wait_src_byte(input logic [7:0] b, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      tick();
      if (bus.dma_src_rd && (bus.dma_src_addr[7:0] == b)) hit = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      tick();
      if (!bus.dma_active) hit = 1'b1;
    end
  endtask

  initial begin
    bus.ppu_mode   = MODE_0;
    bus.reg_rdata  = 8'h00;
    bus.vram_rdata = 8'h00;
    bus.oam_rdata  = 8'h00;
    drive(16'hFF46, 1'b1, 1'b0, 8'h00);
    tick();
    tick();

    check("rst_dma_active", {31'd0, bus.dma_active}, 32'd0);
    check("rst_dma_src_rd", {31'd0, bus.dma_src_rd}, 32'd0);
    check("rst_oam_we", {31'd0, bus.oam_we}, 32'd0);
    check("rst_ff46_shadow", {24'd0, bus.cpu_rdata}, 32'h00);
    rst_n = 1'b1;

    // PPU register write and read pass-through.
    tick();
    drive(16'hFF42, 1'b0, 1'b1, 8'h35);
    check("reg_addr", {16'd0, bus.reg_addr}, 32'hFF42);
    check("reg_we", {31'd0, bus.reg_write_en}, 32'd1);
    check("reg_wdata", {24'd0, bus.reg_wdata}, 32'h35);
    tick();
    drive(16'hFF42, 1'b0, 1'b0, 8'h35);
    check("reg_we_one_clk", {31'd0, bus.reg_write_en}, 32'd0);
    bus.reg_rdata = 8'h90;
    drive(16'hFF44, 1'b1, 1'b0, 8'h00);
    check("reg_rdata", {24'd0, bus.cpu_rdata}, 32'h90);

    // VRAM lock in mode 3.
    tick();
    bus.ppu_mode   = MODE_3;
    bus.vram_rdata = 8'h5A;
    drive(16'h8123, 1'b1, 1'b0, 8'h00);
    check("vram_rd_locked", {24'd0, bus.cpu_rdata}, 32'hFF);
    drive(16'h8123, 1'b0, 1'b1, 8'hA7);
    check("vram_we_locked", {31'd0, bus.vram_we}, 32'd0);
    bus.ppu_mode = MODE_0;
    #1;
    check("vram_we_open", {31'd0, bus.vram_we}, 32'd1);
    check("vram_addr", {19'd0, bus.vram_addr}, 32'h0123);
    drive(16'h8123, 1'b1, 1'b0, 8'h00);
    check("vram_rd_open", {24'd0, bus.cpu_rdata}, 32'h5A);

    // OAM lock in modes 2/3, passthrough in mode 1, unusable and open-bus space.
    tick();
    bus.ppu_mode  = MODE_2;
    bus.oam_rdata = 8'h77;
    drive(16'hFE10, 1'b1, 1'b0, 8'h00);
    check("oam_rd_mode2", {24'd0, bus.cpu_rdata}, 32'hFF);
    drive(16'hFE10, 1'b0, 1'b1, 8'h11);
    check("oam_we_mode2", {31'd0, bus.oam_we}, 32'd0);
    bus.ppu_mode = MODE_1;
    drive(16'hFE10, 1'b1, 1'b0, 8'h00);
    check("oam_rd_mode1", {24'd0, bus.cpu_rdata}, 32'h77);
    drive(16'hFE10, 1'b0, 1'b1, 8'h11);
    check("oam_we_mode1", {31'd0, bus.oam_we}, 32'd1);
    check("oam_addr_cpu", {24'd0, bus.oam_addr}, 32'h10);
    drive(16'hFEA5, 1'b1, 1'b0, 8'h00);
    check("oam_unused_rd", {24'd0, bus.cpu_rdata}, 32'h00);
    drive(16'hC000, 1'b1, 1'b0, 8'h00);
    check("other_rd", {24'd0, bus.cpu_rdata}, 32'hFF);
    drive(16'hFF47, 1'b0, 1'b1, 8'hE4);
    check("reg_we_ff47", {31'd0, bus.reg_write_en}, 32'd1);
    drive(16'hFF46, 1'b0, 1'b1, 8'h00);
    check("reg_we_ff46", {31'd0, bus.reg_write_en}, 32'd0);
    drive(16'hFF4C, 1'b0, 1'b1, 8'h00);
    check("reg_we_ff4c", {31'd0, bus.reg_write_en}, 32'd0);

    // Full DMA from C100.
    tick();
    active_cnt = 0; we_cnt = 0; exp_idx = 0;
    drive(16'hFF46, 1'b0, 1'b1, 8'hC1);
    tick();
    drive(16'hFE10, 1'b1, 1'b0, 8'h00);
    check("dma_active_start", {31'd0, bus.dma_active}, 32'd1);
    check("oam_rd_during_dma", {24'd0, bus.cpu_rdata}, 32'hFF);
    wait_src_byte(8'd3, found);
    check("dma_found_byte3", {31'd0, found}, 32'd1);
    check("dma_src_addr_c1", {16'd0, bus.dma_src_addr}, 32'hC103);
    drive(16'hFE20, 1'b0, 1'b1, 8'h99);
    check("cpu_oam_we_dropped", {31'd0, bus.oam_we}, 32'd0);
    drive(16'h0000, 1'b0, 1'b0, 8'h00);
    wait_idle(found);
    check("dma_done", {31'd0, found}, 32'd1);
    check("dma_active_clocks", active_cnt, 32'd644);
    check("dma_oam_writes", we_cnt, 32'd160);
    drive(16'hFF46, 1'b1, 1'b0, 8'h00);
    check("ff46_shadow", {24'd0, bus.cpu_rdata}, 32'hC1);

    // Echo page fold and restart at byte 50.
    tick();
    active_cnt = 0; we_cnt = 0; exp_idx = 0;
    drive(16'hFF46, 1'b0, 1'b1, 8'hF0);
    tick();
    drive(16'h0000, 1'b0, 1'b0, 8'h00);
    wait_src_byte(8'd50, found);
    check("dma_found_byte50", {31'd0, found}, 32'd1);
    check("dma_src_addr_echo", {16'd0, bus.dma_src_addr}, 32'hD032);
    check("writes_before_restart", we_cnt, 32'd50);
    active_cnt = 0; we_cnt = 0; exp_idx = 0;
    drive(16'hFF46, 1'b0, 1'b1, 8'hC0);
    tick();
    drive(16'h0000, 1'b0, 1'b0, 8'h00);
    check("restart_no_write", we_cnt, 32'd0);
    wait_src_byte(8'd0, found);
    check("restart_found_byte0", {31'd0, found}, 32'd1);
    check("restart_src_addr", {16'd0, bus.dma_src_addr}, 32'hC000);
    wait_idle(found);
    check("restart_done", {31'd0, found}, 32'd1);
    check("restart_active_clocks", active_cnt, 32'd644);
    check("restart_oam_writes", we_cnt, 32'd160);

    // Reset in the middle of a transfer.
    tick();
    active_cnt = 0; we_cnt = 0; exp_idx = 0;
    drive(16'hFF46, 1'b0, 1'b1, 8'hC1);
    tick();
    drive(16'h0000, 1'b0, 1'b0, 8'h00);
    wait_src_byte(8'd80, found);
    check("rst_found_byte80", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_dma_active", {31'd0, bus.dma_active}, 32'd0);
    check("midrst_src_rd", {31'd0, bus.dma_src_rd}, 32'd0);
    check("midrst_oam_we", {31'd0, bus.oam_we}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    active_cnt = 0; stray_cnt = 0;
    for (int k = 0; k < 700; k++) tick();
    check("postrst_active", active_cnt, 32'd0);
    check("postrst_oam_we", stray_cnt, 32'd0);
    drive(16'hFF46, 1'b1, 1'b0, 8'h00);
    check("postrst_shadow", {24'd0, bus.cpu_rdata}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_mmu_bridge.md
Name: ppu_mmu_bridge

Overview:
MMU-side initiator for the PPU register bus, plus CPU access gating for VRAM/OAM and the OAM DMA engine.
- Decodes CPU accesses and drives reg_addr/reg_write_en/reg_wdata toward the PPU, which answers on reg_rdata.
- Blocks CPU VRAM/OAM access according to the current PPU mode.
- Executes FF46-triggered 160-byte OAM DMA.

Parameters:
DMA_CYCLES_PER_BYTE, 4, clocks per DMA byte slot (one M-cycle); legal range 2..15, elaboration error otherwise
OAM_BYTES, 160, bytes per DMA transfer

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_addr  in  16  CPU address
cpu_rd  in  1  CPU read strobe
cpu_wr  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data for decoded regions; comb
ppu_mode  in  2  ppu_mode_t from PPU
reg_addr  out  16  PPU register address
reg_write_en  out  1  PPU register write strobe
reg_wdata  out  8  PPU register write data
reg_rdata  in  8  PPU register read data
vram_addr  out  13  VRAM offset
vram_we  out  1  VRAM write
vram_wdata  out  8  VRAM write data
vram_rdata  in  8  VRAM read data
oam_addr  out  8  OAM index
oam_we  out  1  OAM write
oam_wdata  out  8  OAM write data
oam_rdata  in  8  OAM read data
dma_src_addr  out  16  DMA source address
dma_src_rd  out  1  DMA source read request
dma_src_rdata  in  8  source data, valid the clock after dma_src_rd
dma_active  out  1  DMA in progress

Behaviour:
- Reset (reset low, async): state IDLE, dma_active=0, dma_src_rd=0, DMA oam_we=0, byte index=0, FF46 shadow=8'h00.
- Comb outputs follow inputs; with cpu_wr=0 every write strobe is 0.
- Decode (combinational, zero latency):
  - FF40–FF4B except FF46: reg_addr=cpu_addr, reg_wdata=cpu_wdata, reg_write_en=cpu_wr, cpu_rdata=reg_rdata.
  - FF46 read returns the shadow.
  - 8000–9FFF (VRAM): locked when ppu_mode==MODE_3. Locked reads return 8'hFF; locked writes are dropped (vram_we=0).
  - FE00–FE9F (OAM): locked when ppu_mode is MODE_2 or MODE_3, or when dma_active=1. Locked reads return 8'hFF; locked writes are dropped.
  - FEA0–FEFF reads return 8'h00; writes are ignored.
  - Any other address: cpu_rdata=8'hFF.
- DMA FSM: IDLE -> START -> XFER -> IDLE.
  - FF46 write at clock T: shadow and source high byte latch. If the high byte is E0–FF, store high byte minus 8'h20. Enter START at T+1 with dma_active=1.
  - START: lasts DMA_CYCLES_PER_BYTE clocks, then enter XFER, index i=0.
  - XFER slot i (DMA_CYCLES_PER_BYTE clocks):
    - Slot clock 0: dma_src_rd=1, dma_src_addr={src_hi, i[7:0]}.
    - Slot clock 1: oam_we=1, oam_addr=i, oam_wdata=dma_src_rdata.
  - After slot OAM_BYTES-1 ends, return to IDLE and drop dma_active.
  - dma_active is high for exactly (OAM_BYTES+1)*DMA_CYCLES_PER_BYTE clocks: 644 at defaults.
- FF46 write while DMA is active: the new source latches, the FSM restarts in START, and i resets to 0. No OAM write occurs from the aborted slot if it was at slot clock 0.
- OAM port sharing: DMA owns oam_addr/oam_we/oam_wdata whenever dma_active=1. A CPU OAM write in the same clock is dropped.
- PPU mode change mid-access: the lock is evaluated per clock from the current ppu_mode input.
- Reset mid-DMA: aborts immediately, with no further oam_we or dma_src_rd.

Decomposition:
- Shared ppu package holds: ppu_mode_t (existing); address constants VRAM_BASE/END, OAM_BASE/END, PPU_REG_BASE/END, DMA_REG=16'hFF46; dma_state_t {DMA_IDLE, DMA_START, DMA_XFER}.
- The sub-module oam_dma (FSM, slot counter, byte index, source latch) is natural. The top keeps the decode/lock/read mux.

Test Plan:
- Write FF42=8'h35 with mode 0 -> reg_addr=FF42, reg_write_en=1 for one clock, reg_wdata=8'h35. Read FF44 with reg_rdata=8'h90 -> cpu_rdata=8'h90.
- Mode 3, read 8123 with vram_rdata=8'h5A -> cpu_rdata=8'hFF. Write 8123 -> vram_we=0. Mode 0, same write -> vram_we=1, vram_addr=13'h0123.
- Mode 2, read FE10 -> 8'hFF. Mode 1 -> oam_rdata is passed through.
- Write FF46=8'hC1, memory returns address low byte -> 160 oam_we pulses with oam_addr=i, oam_wdata=i. dma_active high exactly 644 clocks. Read FF46 -> 8'hC1.
- Write FF46=8'hF0 -> dma_src_addr high byte 8'hD0. Rewrite FF46=8'hC0 at byte 50 -> index restarts at 0, and dma_active totals 644 clocks from the second write.
- Pull reset low at byte 80 -> dma_active=0 and oam_we=0 the same cycle. No further writes occur after release.
